// File: rtl/load_store_unit.sv
// Load/store unit between the execute/memory stage and a word-wide DataMemory
// (combinational read, write on posedge). Handles byte/half/word accesses,
// sign/zero extension on loads, and sub-word stores as a read-modify-write.
// Optional build macro: LSU_TRACE_EN prints one line per completed request.
//
// Handshake: a request is taken on the posedge where req_valid && req_ready;
// req_ready is high only in IDLE outside reset, so at most one request is in
// flight. resp_valid is a single-cycle pulse with no backpressure; resp_rdata
// and resp_error stay stable until the next response.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0]  SZ_BYTE    = 2'b00;
    localparam logic [1:0]  SZ_HALF    = 2'b01;
    localparam logic [1:0]  SZ_WORD    = 2'b10;
    localparam logic [1:0]  SZ_ILLEGAL = 2'b11;
    // One extra bit so MEM_WORDS*4 == 2^32 would still compare correctly.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    state_t      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rmw_q;
    logic [31:0] rdata_q;
    logic        error_q;

    logic        accept;
    logic        req_err;
    logic [31:0] load_ext;
    logic [31:0] store_word;

    assign accept    = req_valid && req_ready;
    assign req_ready = (state_q == IDLE) && !rst;
    assign dbg_state = state_q;

    // Classify the incoming request; only meaningful on the acceptance edge.
    always_comb begin
        req_err = 1'b0;
        if (req_size == SZ_ILLEGAL)                        req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0] != 1'b0)    req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
        if ({1'b0, req_addr} >= ADDR_LIMIT)                req_err = 1'b1;
    end

    // Pick the addressed lane out of the memory word and extend it.
    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            SZ_BYTE: begin
                load_ext[7:0]  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
                load_ext[31:8] = unsigned_q ? 24'h0 : {24{load_ext[7]}};
            end
            SZ_HALF: begin
                load_ext[15:0]  = mem_rdata[{addr_q[1], 4'b0000} +: 16];
                load_ext[31:16] = unsigned_q ? 16'h0 : {16{load_ext[15]}};
            end
            default: load_ext = mem_rdata;
        endcase
    end

    // Build the word to write: full word, or the latched word with a lane replaced.
    always_comb begin
        store_word = rmw_q;
        case (size_q)
            SZ_BYTE: store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    // Next-state logic; sub-word stores and loads read first, word stores write directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                                state_d = RESP;
                    else if (req_write && req_size == SZ_WORD)  state_d = WR;
                    else                                        state_d = RD;
                end
            end
            RD:      state_d = write_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs are decoded from state; all forced low during reset.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (!rst) begin
            if (state_q == RD) begin
                mem_read = 1'b1;
                mem_addr = {addr_q[31:2], 2'b00};
            end
            if (state_q == WR) begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = store_word;
            end
        end
    end

    assign resp_valid = (state_q == RESP) && !rst;
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

    // State register, request latch, RMW word latch and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rmw_q      <= 32'h0;
            rdata_q    <= 32'h0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                if (req_err) begin
                    rdata_q <= 32'h0;
                    error_q <= 1'b1;
                end
            end
            if (state_q == RD) begin
                rmw_q <= mem_rdata;
                if (!write_q) begin
                    rdata_q <= load_ext;
                    error_q <= 1'b0;
                end
            end
            if (state_q == WR) begin
                rdata_q <= 32'h0;
                error_q <= 1'b0;
            end
        end
    end

`ifdef LSU_TRACE_EN
    // One trace line per completed request.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP) begin
            if (error_q)
                $display("[LSU ERROR] Addr: %h Size: %0d", addr_q, size_q);
            else if (write_q)
                $display("[LSU ST] Addr: %h Size: %0d Data: %h", addr_q, size_q, wdata_q);
            else
                $display("[LSU LD] Addr: %h Size: %0d Data: %h", addr_q, size_q, rdata_q);
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tb_mem [0:1023];

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DataMemory model: combinational read, write on posedge
    assign mem_rdata = tb_mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_write) tb_mem[mem_addr[11:2]] <= mem_wdata;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic        rd;
        logic        wr;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic w, logic [1:0] sz, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, int lat, logic err, logic [31:0] rdata,
                                logic rd, logic wr, logic [31:0] wd);
        vec_t v;
        v.w = w; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.err = err; v.rdata = rdata; v.rd = rd; v.wr = wr; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Wait (bounded) for req_ready at a negedge; returns 0 on timeout.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Driver: issue one request and observe it until its response.
    task automatic run_req(input vec_t v, output int lat, output logic [31:0] rdata,
                           output logic err, output logic rd, output logic wr,
                           output logic [31:0] wd, output logic [31:0] ad);
        bit ok;
        lat = -1; rdata = 32'hX; err = 1'bX; rd = 1'b0; wr = 1'b0; wd = 32'h0; ad = 32'h0;
        wait_ready(ok);
        if (!ok) return;
        req_write = v.w; req_size = v.sz; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (mem_read)  begin rd = 1'b1; ad = mem_addr; end
            if (mem_write) begin wr = 1'b1; wd = mem_wdata; ad = mem_addr; end
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_error;
                break;
            end
        end
    endtask

    task automatic run_and_check(input vec_t v, input string tag);
        int lat;
        logic [31:0] rdata, wd, ad;
        logic err, rd, wr;
        run_req(v, lat, rdata, err, rd, wr, wd, ad);
        chk({tag, ".latency"}, 32'(lat), 32'(v.lat));
        chk({tag, ".error"}, {31'h0, err}, {31'h0, v.err});
        chk({tag, ".rdata"}, rdata, v.rdata);
        chk({tag, ".mem_read_seen"}, {31'h0, rd}, {31'h0, v.rd});
        chk({tag, ".mem_write_seen"}, {31'h0, wr}, {31'h0, v.wr});
        if (v.wr) chk({tag, ".mem_wdata"}, wd, v.wd);
        if (v.rd || v.wr) chk({tag, ".mem_addr"}, ad, {v.addr[31:2], 2'b00});
    endtask

    initial begin
        bit ok;
        bit saw;
        int bad_ready;
        int acc_cnt;
        int resp_cnt;
        int acc_cyc[6];

        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;

        // reset behaviour (request held on the bus must not be taken)
        repeat (3) begin
            @(negedge clk);
            chk("rst.req_ready", {31'h0, req_ready}, 32'h0);
            chk("rst.mem_write", {31'h0, mem_write}, 32'h0);
            chk("rst.mem_read", {31'h0, mem_read}, 32'h0);
            chk("rst.mem_addr", mem_addr, 32'h0);
            chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        end
        req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("post_rst.req_ready", {31'h0, req_ready}, 32'h1);
        chk("post_rst.resp_rdata", resp_rdata, 32'h0);
        chk("post_rst.resp_error", {31'h0, resp_error}, 32'h0);
        chk("post_rst.state", {30'h0, dbg_state}, 32'h0);

        // w sz uns addr wdata lat err rdata rd wr wd
        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF, 1, 0, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'h123456AA, 3, 0, 32'h0, 1, 1, 32'hDEADAAEF));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 2, 0, 32'hDEADAAEF, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0, 2, 0, 32'hFFFFFFDE, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0, 2, 0, 32'h000000DE, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0, 2, 0, 32'hFFFFDEAD, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h10, 32'h0, 2, 0, 32'h0000AAEF, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h11, 32'h0, 2, 0, 32'hFFFFFFAA, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h10, 32'h0, 2, 0, 32'h000000EF, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h10, 32'h0, 2, 0, 32'hFFFFAAEF, 1, 0, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h12, 32'h0000CAFE, 3, 0, 32'h0, 1, 1, 32'hCAFEAAEF));
        vecs.push_back(mk(0, 2'b10, 1, 32'h10, 32'h0, 2, 0, 32'hCAFEAAEF, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0, 2, 0, 32'h0000CAFE, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h11, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h12, 32'h55555555, 1, 1, 32'h0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h1000, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h1000, 32'h77, 1, 1, 32'h0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 2, 0, 32'hCAFEAAEF, 1, 0, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'hFFC, 32'h80000001, 2, 0, 32'h0, 0, 1, 32'h80000001));
        vecs.push_back(mk(0, 2'b00, 0, 32'hFFC, 32'h0, 2, 0, 32'h00000001, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 0, 32'hFFF, 32'h0, 2, 0, 32'hFFFFFF80, 1, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 32'hFFE, 32'h0, 2, 0, 32'h00008000, 1, 0, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'hFFD, 32'h1234, 1, 1, 32'h0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 32'hFFD, 32'h0000007F, 3, 0, 32'h0, 1, 1, 32'h80007F01));
        vecs.push_back(mk(0, 2'b10, 0, 32'hFFC, 32'h0, 2, 0, 32'h80007F01, 1, 0, 32'h0));

        foreach (vecs[i]) run_and_check(vecs[i], $sformatf("vec%0d", i));

        // response registers hold between responses
        repeat (3) @(negedge clk);
        chk("hold.resp_rdata", resp_rdata, 32'h80007F01);
        chk("hold.resp_valid", {31'h0, resp_valid}, 32'h0);

        // reset during the write cycle of a byte RMW
        run_and_check(mk(1, 2'b10, 0, 32'h20, 32'h11223344, 2, 0, 32'h0, 0, 1, 32'h11223344), "rmw_pre");
        wait_ready(ok);
        chk("rmw_rst.ready", {31'h0, ok}, 32'h1);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h000000FF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rst.rd_cycle_mem_read", {31'h0, mem_read}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rmw_rst.mem_write_gated", {31'h0, mem_write}, 32'h0);
        chk("rmw_rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rmw_rst.ready_after", {31'h0, req_ready}, 32'h1);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) saw = 1'b1;
        end
        chk("rmw_rst.no_resp", {31'h0, saw}, 32'h0);
        chk("rmw_rst.mem_unchanged", tb_mem[8], 32'h11223344);
        run_and_check(mk(0, 2'b10, 0, 32'h20, 32'h0, 2, 0, 32'h11223344, 1, 0, 32'h0), "rmw_rst.readback");

        // back-to-back: req_valid held high, alternating lw / sw
        bad_ready = 0; acc_cnt = 0; resp_cnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    req_write = i[0]; req_size = 2'b10; req_unsigned = 1'b0;
                    req_addr = i[0] ? 32'h30 : 32'h10;
                    req_wdata = 32'hB0B0_0000 | 32'(i);
                    req_valid = 1'b1;
                    wait_ready(ok);
                    if (!ok) break;
                    acc_cyc[i] = cyc;
                    acc_cnt++;
                    exp_q.push_back(i[0] ? 32'h0 : 32'hCAFEAAEF);
                    @(posedge clk);
                    #1;
                end
                req_valid = 1'b0;
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (req_ready && (mem_read || mem_write || resp_valid)) bad_ready++;
                    if (resp_valid) begin
                        resp_cnt++;
                        if (exp_q.size() == 0) chk("b2b.unexpected_resp", resp_rdata, 32'hX);
                        else chk("b2b.rdata", resp_rdata, exp_q.pop_front());
                        chk("b2b.error", {31'h0, resp_error}, 32'h0);
                    end
                end
            end
        join
        chk("b2b.accepted", 32'(acc_cnt), 32'd6);
        chk("b2b.responses", 32'(resp_cnt), 32'd6);
        chk("b2b.ready_low_busy", 32'(bad_ready), 32'd0);
        for (int i = 1; i < 6; i++)
            if (i < acc_cnt) chk($sformatf("b2b.spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        chk("b2b.last_store", tb_mem[12], 32'hB0B00005);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute/memory stage and `DataMemory`, which is word-wide, has a combinational read, and writes on the clock edge.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Performs lane extraction and sign/zero extension for loads.
- Implements sub-word stores as a two-cycle read-modify-write on the word memory.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words behind the unit; byte address limit is MEM_WORDS*4.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle, can accept a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data, 0 for stores and errors
- resp_error  output  1  misaligned, out-of-range or illegal size; valid with resp_valid
- mem_read  output  1  to DataMemory mem_read
- mem_write  output  1  to DataMemory mem_write
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  output  32  full word to write
- mem_rdata  input  32  DataMemory read_data

Behaviour:
- Reset:
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_error=0.
  - req_ready=0 while rst=1.
  - mem_read, mem_write, mem_addr, mem_wdata are all 0 while rst=1.
- States: IDLE, RD, WR, RESP.
- req_ready = (state==IDLE) && !rst.
- Handshake: a request is accepted on the edge where req_valid && req_ready; all req_* fields are latched at that edge. Inputs are ignored outside IDLE.
- Error check at acceptance. The request is in error if any of:
  - size==11
  - half with addr[0]!=0
  - word with addr[1:0]!=0
  - addr >= MEM_WORDS*4
- On error: IDLE→RESP directly; no mem_read or mem_write is ever asserted; resp_error=1, resp_rdata=0.
- Load (acceptance edge N):
  - IDLE→RD.
  - Cycle N+1: mem_read=1, mem_addr=aligned address. At the end of that cycle, capture the extracted and extended data.
  - RD→RESP.
  - Cycle N+2: resp_valid=1.
- Word store:
  - IDLE→WR.
  - Cycle N+1: mem_write=1, mem_wdata=req_wdata.
  - Cycle N+2: RESP.
- Byte/half store:
  - IDLE→RD.
  - Cycle N+1: mem_read=1; latch mem_rdata.
  - RD→WR.
  - Cycle N+2: mem_write=1, mem_wdata = latched word with the target lane(s) replaced by req_wdata[7:0] or req_wdata[15:0].
  - Cycle N+3: RESP.
- Lanes: little-endian. Byte lane = addr[1:0]; half lane = addr[1].
- Extension:
  - lb/lh replicate bit 7/15.
  - lbu/lhu zero-fill.
  - lw ignores req_unsigned.
- RESP lasts exactly one cycle, then →IDLE. There is no response backpressure.
- Outputs by state:
  - mem_* outputs are combinational from state and latched request.
  - mem_* are 0 in IDLE and RESP.
  - resp_rdata and resp_error hold their values until the next RESP.
- Reset mid-operation:
  - Next state is IDLE and the in-flight request is dropped.
  - No resp_valid is issued for the dropped request.
  - mem_write is gated by !rst in the same cycle, so an RMW interrupted in RD or WR never writes.
- Back-to-back: the minimum issue interval is 3 cycles (load, word store) or 4 cycles (sub-word store).

Optional Feature:
- Macro: LSU_TRACE_EN.
- Defined: in every RESP cycle, print one line:
  - loads: "[LSU LD] Addr: %h Size: %0d Data: %h"
  - stores: "[LSU ST] Addr: %h Size: %0d Data: %h"
  - errors: "[LSU ERROR] Addr: %h Size: %0d"
- Not defined: no display statements are compiled. Cycle behaviour is identical either way.

Test Plan:
- sw addr 0x10 data 0xDEADBEEF accepted at N → N+1 mem_write=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; N+2 resp_valid=1, resp_error=0. Then lw 0x10 → resp_rdata=0xDEADBEEF two cycles after acceptance.
- sb addr 0x11 data 0x123456AA onto 0xDEADBEEF → N+1 mem_read=1; N+2 mem_wdata=0xDEADAAEF; N+3 resp_valid. Then sh addr 0x12 data 0x0000CAFE → word becomes 0xCAFEAAEF.
- Memory word 0xDEADAAEF at 0x10 → lb 0x13 gives 0xFFFFFFDE; lbu 0x13 gives 0x000000DE; lh 0x12 gives 0xFFFFDEAD; lhu 0x10 gives 0x0000AAEF.
- Error cases → resp_valid at N+1 with resp_error=1, resp_rdata=0, and no mem_read/mem_write in any cycle:
  - lh 0x11
  - sw 0x12
  - lw 0x1000 with MEM_WORDS=1024
  - req_size=11
  - Afterwards, a readback of 0x10 is unchanged.
- Assert rst during cycle N+2 (WR) of an sb → mem_write=0 that cycle; word unchanged; resp_valid never pulses; req_ready=1 the cycle after rst deasserts.
- Hold req_valid=1 with alternating lw/sw for 6 requests → req_ready is low during RD/WR/RESP; each request is accepted exactly once, in order, with 3-cycle spacing; 6 resp_valid pulses.
